// File: rtl/pwm_bank_pkg.sv
// rtl/pwm_bank_pkg.sv - shared constants and helpers for the PWM bank
package pwm_bank_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// rtl/pwm_bank_if.sv - configuration write and sync bus of the PWM bank
interface pwm_bank_if import pwm_bank_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = ch_w(NUM_CH);

    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_duty;
    logic             cfg_enable;
    logic             cfg_polarity;
    logic             cfg_center;
    logic             sync_load;

    modport master (
        output cfg_wr, cfg_ch, cfg_period, cfg_duty,
        output cfg_enable, cfg_polarity, cfg_center, sync_load
    );

    modport slave (
        input cfg_wr, cfg_ch, cfg_period, cfg_duty,
        input cfg_enable, cfg_polarity, cfg_center, sync_load
    );

endinterface

// File: rtl/pwm_bank_channel.sv
// rtl/pwm_bank_channel.sv - one PWM channel: shadow/active sets, counter, compare, boundary
module pwm_bank_channel import pwm_bank_pkg::*; #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             sync_load,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic             enable,
    input  logic             polarity,
    input  logic             center,
    output logic             pwm_out,
    output logic             period_end,
    output logic             pending
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] sh_period, sh_duty, ac_period, ac_duty, cnt, last;
    logic             sh_en, sh_pol, sh_ctr, ac_en, ac_pol, ac_ctr, dir;
    logic             running, terminal, load, nx_run, raw;

    always_comb begin
        running = ac_en && (ac_period != '0);
        last    = ac_period - ONE;
        if (ac_ctr == MODE_EDGE)
            terminal = running && (cnt == last);
        else
            terminal = running && (cnt == '0) && (dir == DIR_DOWN);
        // Idle channels reload every cycle, so a fresh write starts without waiting for a boundary.
        load   = sync_load || !running || terminal;
        nx_run = wr ? (enable && (period != '0)) : (sh_en && (sh_period != '0));
        raw    = cnt < ac_duty;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_period  <= '0;
            sh_duty    <= '0;
            sh_en      <= 1'b0;
            sh_pol     <= 1'b0;
            sh_ctr     <= 1'b0;
            ac_period  <= '0;
            ac_duty    <= '0;
            ac_en      <= 1'b0;
            ac_pol     <= 1'b0;
            ac_ctr     <= 1'b0;
            cnt        <= '0;
            dir        <= DIR_UP;
            pwm_out    <= 1'b0;
            period_end <= 1'b0;
            pending    <= 1'b0;
        end else begin
            if (wr) begin
                sh_period <= period;
                sh_duty   <= duty;
                sh_en     <= enable;
                sh_pol    <= polarity;
                sh_ctr    <= center;
            end
            pwm_out <= running ? (raw ^ ac_pol) : ac_pol;
            if (load) begin
                ac_period  <= wr ? period   : sh_period;
                ac_duty    <= wr ? duty     : sh_duty;
                ac_en      <= wr ? enable   : sh_en;
                ac_pol     <= wr ? polarity : sh_pol;
                ac_ctr     <= wr ? center   : sh_ctr;
                cnt        <= '0;
                dir        <= DIR_UP;
                pending    <= 1'b0;
                period_end <= sync_load ? nx_run : terminal;
            end else begin
                pending    <= pending | wr;
                period_end <= 1'b0;
                if (ac_ctr == MODE_EDGE)
                    cnt <= cnt + ONE;
                else if (dir == DIR_DOWN)
                    cnt <= cnt - ONE;
                else if (cnt == last)
                    dir <= DIR_DOWN;
                else
                    cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM bank: channel decode and sync fan-out
module pwm_bank import pwm_bank_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_bank_if.slave         cfg,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] period_end,
    output logic [NUM_CH-1:0] pending
);

    localparam int CH_W = ch_w(NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);
        // Out-of-range channel numbers match no instance and are dropped.
        logic wr_sel;
        assign wr_sel = cfg.cfg_wr && (cfg.cfg_ch == IDX);

        pwm_bank_channel #(.CNT_W(CNT_W)) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr         (wr_sel),
            .sync_load  (cfg.sync_load),
            .period     (cfg.cfg_period),
            .duty       (cfg.cfg_duty),
            .enable     (cfg.cfg_enable),
            .polarity   (cfg.cfg_polarity),
            .center     (cfg.cfg_center),
            .pwm_out    (pwm_out[i]),
            .period_end (period_end[i]),
            .pending    (pending[i])
        );
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - scoreboard bench for pwm_bank
module tb_pwm_bank;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] pwm_out, period_end, pending;
    int                cyc = 0;
    int                total = 0;
    int                bad = 0;

    typedef struct {
        int    cyc;
        int    ch;
        int    sig;
        logic  val;
        string tag;
    } exp_t;
    exp_t sb[$];

    pwm_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus();

    pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (bus),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .pending    (pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string ph, input int base, input int k, input int ch,
                            input int sig, input logic val);
        exp_t  e;
        string nm;
        nm    = (sig == 0) ? "pwm" : ((sig == 1) ? "pe" : "pend");
        e.cyc = base + k;
        e.ch  = ch;
        e.sig = sig;
        e.val = val;
        e.tag = $sformatf("%s ch%0d %s k=%0d", ph, ch, nm, k);
        sb.push_back(e);
    endtask

    function automatic logic get_sig(input int ch, input int sig);
        case (sig)
            0:       return pwm_out[ch];
            1:       return period_end[ch];
            default: return pending[ch];
        endcase
    endfunction

    function automatic logic ctr_act(input int j, input int p, input int d);
        int f;
        f = (j < p) ? j : (2 * p - 1 - j);
        return f < d;
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_val(sb[i].tag, 32'(get_sig(sb[i].ch, sb[i].sig)), 32'(sb[i].val));
                sb.delete(i);
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_cfg(input int ch, input int p, input int d, input logic en,
                          input logic pol, input logic ctr);
        bus.cfg_ch       = 2'(ch);
        bus.cfg_period   = 16'(p);
        bus.cfg_duty     = 16'(d);
        bus.cfg_enable   = en;
        bus.cfg_polarity = pol;
        bus.cfg_center   = ctr;
        bus.cfg_wr       = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_wr = 1'b0;
    endtask

    initial begin
        int c;
        rst_n            = 1'b0;
        bus.cfg_wr       = 1'b0;
        bus.cfg_ch       = '0;
        bus.cfg_period   = '0;
        bus.cfg_duty     = '0;
        bus.cfg_enable   = 1'b0;
        bus.cfg_polarity = 1'b0;
        bus.cfg_center   = 1'b0;
        bus.sync_load    = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int s = 0; s < 3; s++) push_exp("reset", 0, 1, ch, s, 1'b0);
        wait_to(2);
        rst_n = 1'b1;
        wait_to(3);

        // Edge mode P=10 D=3, then duty 7 written mid-period at cnt=5
        c = cyc;
        for (int k = 1; k <= 31; k++) begin
            int m, p;
            m = (k - 2) % 10;
            p = (k - 2) / 10;
            push_exp("edge", c, k, 0, 0, (k >= 2) && (m < ((p < 2) ? 3 : 7)));
            push_exp("edge", c, k, 0, 1, (k == 11) || (k == 21) || (k == 31));
            push_exp("edge", c, k, 0, 2, (k >= 17) && (k <= 20));
        end
        wr_cfg(0, 10, 3, 1'b1, 1'b0, 1'b0);
        wait_to(c + 16);
        wr_cfg(0, 10, 7, 1'b1, 1'b0, 1'b0);
        wait_to(c + 32);

        // Center mode P=8 D=2 on ch1
        c = cyc;
        for (int k = 1; k <= 33; k++) begin
            push_exp("center", c, k, 1, 0, (k >= 2) && ctr_act((k - 2) % 16, 8, 2));
            push_exp("center", c, k, 1, 1, (k == 17) || (k == 33));
            if (k <= 4) push_exp("center", c, k, 1, 2, 1'b0);
        end
        wr_cfg(1, 8, 2, 1'b1, 1'b0, 1'b1);
        wait_to(c + 34);

        // Polarity and duty extremes on ch2
        c = cyc;
        for (int k = 1; k <= 20; k++) begin
            push_exp("pol", c, k, 2, 0, ((k >= 2) && (k <= 11)) || (k >= 17));
            push_exp("pol", c, k, 2, 1, (k == 6) || (k == 11) || (k == 16));
            push_exp("pol", c, k, 2, 2, ((k >= 7) && (k <= 10)) || (k == 14) || (k == 15));
        end
        wr_cfg(2, 5, 0, 1'b1, 1'b1, 1'b0);
        wait_to(c + 6);
        wr_cfg(2, 5, 5, 1'b1, 1'b1, 1'b0);
        wait_to(c + 13);
        wr_cfg(2, 5, 5, 1'b0, 1'b1, 1'b0);
        wait_to(c + 21);

        // sync_load with a same-cycle write to ch2
        c = cyc;
        for (int ch = 0; ch < NUM_CH; ch++) push_exp("sync", c, 1, ch, 1, 1'b1);
        push_exp("sync", c, 1, 2, 2, 1'b0);
        push_exp("sync", c, 1, 2, 0, 1'b1);
        for (int k = 2; k <= 21; k++) begin
            push_exp("sync", c, k, 0, 0, ((k - 2) % 10) < 7);
            push_exp("sync", c, k, 0, 1, (k == 11) || (k == 21));
            if (k <= 15) begin
                push_exp("sync", c, k, 2, 0, ((k - 2) % 7) < 3);
                push_exp("sync", c, k, 2, 1, (k == 8) || (k == 15));
            end
            if (k <= 19) begin
                push_exp("sync", c, k, 1, 0, ctr_act((k - 2) % 16, 8, 2));
                push_exp("sync", c, k, 1, 1, k == 17);
            end
        end
        bus.sync_load = 1'b1;
        wr_cfg(2, 7, 3, 1'b1, 1'b0, 1'b0);
        bus.sync_load = 1'b0;
        wait_to(c + 22);

        // Out-of-range channel write must not touch any channel
        c = cyc;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            push_exp("badch", c, 1, ch, 2, 1'b0);
            push_exp("badch", c, 2, ch, 2, 1'b0);
        end
        wr_cfg(NUM_CH, 1, 1, 1'b1, 1'b0, 1'b0);
        wait_to(c + 2);

        // P=1 D=1 edge mode: constant active, period_end every cycle
        c = cyc;
        for (int k = 1; k <= 6; k++) begin
            push_exp("p1", c, k, 1, 1, 1'b1);
            if (k >= 2) push_exp("p1", c, k, 1, 0, 1'b1);
        end
        bus.sync_load = 1'b1;
        wr_cfg(1, 1, 1, 1'b1, 1'b0, 1'b0);
        bus.sync_load = 1'b0;
        wait_to(c + 6);

        // Reset mid-period
        c = cyc;
        for (int k = 1; k <= 4; k++)
            for (int ch = 0; ch < NUM_CH; ch++)
                for (int s = 0; s < 3; s++) push_exp("rst_mid", c, k, ch, s, 1'b0);
        rst_n = 1'b0;
        wait_to(c + 2);
        rst_n = 1'b1;
        wait_to(c + 6);

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
